// File: rtl/nave_controle_if.sv
// Shot request/acknowledge channel between the ship controller and the projectile logic.
interface nave_controle_if;
  logic        shot_req;
  logic [10:0] shot_x;
  logic        shot_ack;

  modport master (output shot_req, output shot_x, input shot_ack);
  modport slave  (input shot_req, input shot_x, output shot_ack);
endinterface

// File: rtl/nave_controle.sv
// Player ship control: button sync/debounce, frame-rate motion with acceleration and
// edge clamping, and fire requests with a frame-based cooldown.
module nave_controle #(
  parameter int SCREEN_W        = 640,
  parameter int SHIP_W          = 22,
  parameter int X_MIN           = 0,
  parameter int X_RESET         = 309,
  parameter int FRAME_LINE      = 480,
  parameter int MAX_SPEED       = 4,
  parameter int ACCEL_FRAMES    = 8,
  parameter int COOLDOWN_FRAMES = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   btn_A,
  input  logic                   btn_B,
  input  logic                   btn_C,
  input  logic [9:0]             h_counter,
  input  logic [9:0]             v_counter,
  output logic [10:0]            posX,
  output logic                   frame_tick,
  nave_controle_if.master        shot
);

  localparam int SPD_W = $clog2(MAX_SPEED + 1);
  localparam int ACC_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
  localparam int CD_W  = $clog2(COOLDOWN_FRAMES + 1);

  localparam logic [10:0] X_LEFT   = 11'(X_MIN);
  localparam logic [10:0] X_RIGHT  = 11'(SCREEN_W - SHIP_W);
  localparam logic [10:0] SHOT_OFS = 11'(SHIP_W / 2 - 1);

  typedef enum logic [1:0] {IDLE, MOVE_L, MOVE_R} state_t;

  // Bit order in the 3-bit button vectors: [0]=left, [1]=right, [2]=fire.
  logic [2:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]       smp_q, smp_d, deb_q, deb_d;
  logic             cond_q, cond_d, frame_tick_q, frame_tick_d;
  state_t           state_q, state_d, next_state;
  logic [SPD_W-1:0] speed_q, speed_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_inc;
  logic [10:0]      posX_q, posX_d, step;
  logic             req_q, req_d;
  logic [10:0]      shot_x_q, shot_x_d;
  logic [CD_W-1:0]  cd_q, cd_d;

  logic [2:0] level, eq;
  logic       cond, left, right, fire_rise;

  always_comb begin
    sync1_d      = {btn_C, btn_B, btn_A};
    sync2_d      = sync1_q;
    level        = ~sync2_q;
    cond         = (v_counter == 10'(FRAME_LINE)) && (h_counter == '0);
    cond_d       = cond;
    frame_tick_d = cond & ~cond_q;

    smp_d      = smp_q;
    deb_d      = deb_q;
    state_d    = state_q;
    next_state = state_q;
    speed_d    = speed_q;
    acc_d      = acc_q;
    acc_inc    = acc_q + ACC_W'(1);
    posX_d     = posX_q;
    req_d      = req_q;
    shot_x_d   = shot_x_q;
    cd_d       = cd_q;
    step       = '0;
    eq         = ~(smp_q ^ level);
    fire_rise  = 1'b0;
    left       = deb_q[0] & ~deb_q[1];
    right      = deb_q[1] & ~deb_q[0];

    if (frame_tick_q) begin
      // Debounced level follows only when this tick's sample matches the previous one.
      smp_d     = level;
      deb_d     = (eq & level) | (~eq & deb_q);
      fire_rise = deb_d[2] & ~deb_q[2];

      if (fire_rise && !req_q && (cd_q == '0)) begin
        req_d    = 1'b1;
        shot_x_d = posX_q + SHOT_OFS;
      end
      if (cd_q != '0) cd_d = cd_q - CD_W'(1);

      if (left || right) begin
        next_state = left ? MOVE_L : MOVE_R;
        state_d    = next_state;
        if (state_q != next_state) begin
          step    = 11'd1;
          speed_d = SPD_W'(1);
          acc_d   = '0;
        end else begin
          step = 11'(speed_q);
          if (acc_inc == ACC_W'(ACCEL_FRAMES - 1)) begin
            acc_d = '0;
            if (speed_q < SPD_W'(MAX_SPEED)) speed_d = speed_q + SPD_W'(1);
          end else begin
            acc_d = acc_inc;
          end
        end
        if (left) posX_d = (posX_q < X_LEFT + step) ? X_LEFT : posX_q - step;
        else      posX_d = (posX_q + step > X_RIGHT) ? X_RIGHT : posX_q + step;
      end else begin
        state_d = IDLE;
        speed_d = '0;
        acc_d   = '0;
      end
    end

    // Ack wins over a same-cycle tick decrement so the full cooldown is loaded.
    if (req_q && shot.shot_ack) begin
      req_d = 1'b0;
      cd_d  = CD_W'(COOLDOWN_FRAMES);
    end
  end

  // cond_q resets high so a tick after reset needs a fresh rise of the frame condition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= '1;
      sync2_q      <= '1;
      smp_q        <= '0;
      deb_q        <= '0;
      cond_q       <= 1'b1;
      frame_tick_q <= 1'b0;
      state_q      <= IDLE;
      speed_q      <= '0;
      acc_q        <= '0;
      posX_q       <= 11'(X_RESET);
      req_q        <= 1'b0;
      shot_x_q     <= '0;
      cd_q         <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      smp_q        <= smp_d;
      deb_q        <= deb_d;
      cond_q       <= cond_d;
      frame_tick_q <= frame_tick_d;
      state_q      <= state_d;
      speed_q      <= speed_d;
      acc_q        <= acc_d;
      posX_q       <= posX_d;
      req_q        <= req_d;
      shot_x_q     <= shot_x_d;
      cd_q         <= cd_d;
    end
  end

  assign posX          = posX_q;
  assign frame_tick    = frame_tick_q;
  assign shot.shot_req = req_q;
  assign shot.shot_x   = shot_x_q;

endmodule

// File: tb/tb_nave_controle.sv
// Self-checking bench for nave_controle: directed scenarios plus randomized button play,
// compared against a frame-level behavioural model of the ship.
module tb_nave_controle;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_A, btn_B, btn_C;
  logic [9:0]  h_counter, v_counter;
  logic [10:0] posX;
  logic        frame_tick;

  nave_controle_if sif();

  nave_controle #(
    .SCREEN_W(640), .SHIP_W(22), .X_MIN(0), .X_RESET(309), .FRAME_LINE(480),
    .MAX_SPEED(4), .ACCEL_FRAMES(8), .COOLDOWN_FRAMES(15)
  ) dut (
    .clk(clk), .reset(reset), .btn_A(btn_A), .btn_B(btn_B), .btn_C(btn_C),
    .h_counter(h_counter), .v_counter(v_counter), .posX(posX),
    .frame_tick(frame_tick), .shot(sif.master)
  );

  always #5 clk = ~clk;

  localparam int XR = 640 - 22;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  int nt;
  int hold;
  bit rl, rr, rf;

  // Frame-level model state
  bit [2:0] m_smp, m_deb;
  int       m_dir, m_spd, m_acc, m_pos, m_cd, m_sx;
  bit       m_req;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_smp = '0; m_deb = '0;
    m_dir = 0; m_spd = 0; m_acc = 0; m_pos = 309; m_cd = 0; m_sx = 0; m_req = 1'b0;
  endtask

  // One frame of ship behaviour given the (active-high) button levels held before the tick.
  task automatic model_tick(input bit l, input bit r, input bit f);
    bit [2:0] lvl, old;
    bit       accept;
    int       want, step;
    lvl = {f, r, l};
    old = m_deb;
    for (int i = 0; i < 3; i++)
      if (m_smp[i] == lvl[i]) m_deb[i] = lvl[i];
    m_smp = lvl;
    accept = m_deb[2] && !old[2] && !m_req && (m_cd == 0);
    if (m_cd > 0) m_cd--;
    if (accept) begin
      m_req = 1'b1;
      m_sx  = m_pos + 22 / 2 - 1;
    end
    want = (old[0] && !old[1]) ? -1 : ((old[1] && !old[0]) ? 1 : 0);
    if (want == 0) begin
      m_dir = 0; m_spd = 0; m_acc = 0;
    end else begin
      if (want != m_dir) begin
        step = 1; m_spd = 1; m_acc = 0;
      end else begin
        step = m_spd;
        m_acc++;
        if (m_acc == 8 - 1) begin
          m_acc = 0;
          if (m_spd < 4) m_spd++;
        end
      end
      m_dir = want;
      if (want < 0) m_pos = (m_pos - step < 0) ? 0 : m_pos - step;
      else          m_pos = (m_pos + step > XR) ? XR : m_pos + step;
    end
  endtask

  task automatic run_frame(input bit l, input bit r, input bit f);
    int n;
    btn_A = ~l; btn_B = ~r; btn_C = ~f;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 400);
    check("tick_seen", frame_tick, 1'b1);
    model_tick(l, r, f);
    @(posedge clk); #1;
    check("posX", posX, m_pos);
    check("shot_req", sif.shot_req, m_req);
    check("shot_x", sif.shot_x, m_sx);
    check("tick_width", frame_tick, 1'b0);
  endtask

  task automatic do_ack(input int dly);
    repeat (dly) @(posedge clk);
    #1 sif.shot_ack = 1'b1;
    @(posedge clk); #1 sif.shot_ack = 1'b0;
    if (m_req) begin
      m_req = 1'b0;
      m_cd  = 15;
    end
    check("shot_req_after_ack", sif.shot_req, m_req);
  endtask

  // VGA counter stand-in: 8 pixels x 8 lines around the frame line, one pixel every 2 clocks.
  initial begin
    h_counter = '0;
    v_counter = 10'd476;
    forever begin
      repeat (2) @(posedge clk);
      #1;
      if (h_counter == 10'd7) begin
        h_counter = '0;
        v_counter = (v_counter == 10'd483) ? 10'd476 : v_counter + 10'd1;
      end else begin
        h_counter = h_counter + 10'd1;
      end
    end
  end

  initial begin
    reset = 1'b1;
    btn_A = 1'b1; btn_B = 1'b1; btn_C = 1'b1;
    sif.shot_ack = 1'b0;
    model_reset();
    repeat (3) @(posedge clk); #1;
    check("rst_posX", posX, 309);
    check("rst_shot_req", sif.shot_req, 0);
    check("rst_shot_x", sif.shot_x, 0);
    check("rst_frame_tick", frame_tick, 0);
    @(negedge clk) reset = 1'b0;

    // Idle for five frames: one tick each, ship centred
    nt = 0;
    repeat (640) begin
      @(negedge clk);
      if (frame_tick) nt++;
    end
    check("ticks_in_5_frames", nt, 5);
    check("idle_posX", posX, 309);
    check("idle_shot_req", sif.shot_req, 0);

    // Fire from centre, ack, then cooldown boundary
    run_frame(0, 0, 1);
    run_frame(0, 0, 1);
    check("fire_req", sif.shot_req, 1);
    check("fire_shot_x", sif.shot_x, 319);
    do_ack(3);
    repeat (2) run_frame(0, 0, 0);
    repeat (2) run_frame(0, 0, 1);
    check("fire_in_cooldown", sif.shot_req, 0);
    do_ack(2);
    repeat (9) run_frame(0, 0, 0);
    repeat (2) run_frame(0, 0, 1);
    check("fire_cooldown_last", sif.shot_req, 0);
    repeat (2) run_frame(0, 0, 0);
    repeat (2) run_frame(0, 0, 1);
    check("fire_after_cooldown", sif.shot_req, 1);
    do_ack(2);

    // Motion: hold left, glitch, run into right clamp, both pressed, restart right
    repeat (20) run_frame(1, 0, 0);
    repeat (3) run_frame(0, 0, 0);
    run_frame(1, 0, 0);
    repeat (3) run_frame(0, 0, 0);
    repeat (120) run_frame(0, 1, 0);
    check("right_clamp", posX, XR);
    repeat (4) run_frame(1, 1, 0);
    repeat (3) run_frame(0, 1, 0);
    repeat (3) run_frame(0, 0, 0);

    // Randomized button play with random acks
    hold = 0;
    for (int i = 0; i < 60; i++) begin
      if (hold == 0) begin
        rl = 1'($urandom_range(0, 1));
        rr = 1'($urandom_range(0, 1));
        rf = 1'($urandom_range(0, 1));
        hold = int'($urandom_range(1, 4));
      end
      run_frame(rl, rr, rf);
      hold--;
      if (m_req && ($urandom_range(0, 2) == 0)) do_ack(int'($urandom_range(1, 5)));
    end

    // Asynchronous reset while moving right with a pending shot
    if (m_req) do_ack(2);
    repeat (17) run_frame(0, 0, 0);
    repeat (4) run_frame(0, 1, 1);
    check("pre_reset_req", sif.shot_req, 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_posX", posX, 309);
    check("async_rst_shot_req", sif.shot_req, 0);
    check("async_rst_shot_x", sif.shot_x, 0);
    check("async_rst_frame_tick", frame_tick, 0);
    btn_A = 1'b1; btn_B = 1'b1; btn_C = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    model_reset();
    repeat (2) run_frame(0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
